// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard controller: load-use and mul/div interlocks, branch flush priority,
// and a saturating count of stall cycles for the 5-stage MIPS pipeline.
module hazard_stall_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_STALL = 1,
    parameter int MD_LAT     = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead_ex,
    input  logic [ADDR_W-1:0] RegWriteAddr_ex,
    input  logic [ADDR_W-1:0] RsAddr_id,
    input  logic [ADDR_W-1:0] RtAddr_id,
    input  logic              RsUsed_id,
    input  logic              RtUsed_id,
    input  logic              MdStart_ex,
    input  logic              HiLoRead_id,
    input  logic              BranchTaken_ex,
    output logic              stall,
    output logic              PC_IFWrite,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic {IDLE, LSTALL} stateT;

    localparam logic [2:0] LCNT_INIT = 3'(LOAD_STALL - 1);
    localparam logic [3:0] MCNT_INIT = 4'(MD_LAT);

    stateT      state, stateNext;
    logic [2:0] lcnt, lcntNext;
    logic [3:0] mcnt;
    logic       luHit, luStall, mdStall;

    // Register $0 never carries a real dependency, so it is excluded from the match.
    assign luHit = MemRead_ex && (RegWriteAddr_ex != '0) &&
                   ((RsUsed_id && (RegWriteAddr_ex == RsAddr_id)) ||
                    (RtUsed_id && (RegWriteAddr_ex == RtAddr_id)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lcnt  <= '0;
        end else begin
            state <= stateNext;
            lcnt  <= lcntNext;
        end
    end

    // The first stall cycle comes from IDLE itself; LSTALL covers the remaining ones.
    always_comb begin
        stateNext = state;
        lcntNext  = lcnt;
        luStall   = 1'b0;
        case (state)
            IDLE: begin
                if (luHit) begin
                    luStall = 1'b1;
                    if (!BranchTaken_ex && (LOAD_STALL > 1)) begin
                        stateNext = LSTALL;
                        lcntNext  = LCNT_INIT;
                    end
                end
            end
            LSTALL: begin
                luStall = 1'b1;
                if (BranchTaken_ex || (lcnt == 3'd1)) begin
                    stateNext = IDLE;
                    lcntNext  = '0;
                end else begin
                    lcntNext = lcnt - 3'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                lcntNext  = '0;
            end
        endcase
    end

    // A mul/div already in flight is not cancelled by a branch flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= '0;
        end else if (MdStart_ex) begin
            mcnt <= MCNT_INIT;
        end else if (mcnt != '0) begin
            mcnt <= mcnt - 4'd1;
        end
    end

    assign md_busy     = (mcnt != '0);
    assign mdStall     = HiLoRead_id && md_busy;
    assign stall       = (luStall || mdStall) && !BranchTaken_ex;
    assign PC_IFWrite  = !stall;
    assign IF_ID_Flush = BranchTaken_ex;
    assign ID_EX_Flush = stall || BranchTaken_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
